muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_core.sv | 70 +++++++
 rtl/muldiv_unit.sv | 138 +++++++++++++
 tb/tb_muldiv_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared MIPS mult/div definitions: R-type funct codes and FSM state
// encodings. Control and hazard units import this same package.
package muldiv_pkg;

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MTLO  = 6'b010011;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   function automatic logic is_mul(input logic [5:0] f);
      return (f == F_MULT) || (f == F_MULTU);
   endfunction

   function automatic logic is_div(input logic [5:0] f);
      return (f == F_DIV) || (f == F_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide,
// one bit per step. Operands arrive already as magnitudes.
module muldiv_core
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic             div_i,
   input  logic [WIDTH-1:0] seed_i,   // multiplier or dividend, shifts through lo
   input  logic [WIDTH-1:0] opnd_i,   // multiplicand or divisor
   input  logic             step_i,
   output logic             div_o,
   output logic [WIDTH-1:0] res_hi_o, // value after the current step
   output logic [WIDTH-1:0] res_lo_o
);

   logic [WIDTH:0]   acc_q, acc_d, sum, shifted, trial;
   logic [WIDTH-1:0] lo_q, lo_d, opnd_q;
   logic             div_q;

   // One iteration step; acc carries an extra bit for the add carry / borrow sign
   always_comb begin
      acc_d   = acc_q;
      lo_d    = lo_q;
      sum     = '0;
      shifted = '0;
      trial   = '0;
      if (div_q) begin
         shifted = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
         trial   = shifted - {1'b0, opnd_q};
         if (!trial[WIDTH]) begin
            acc_d = trial;
            lo_d  = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_d = shifted;
            lo_d  = {lo_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         sum   = lo_q[0] ? (acc_q + {1'b0, opnd_q}) : acc_q;
         acc_d = {1'b0, sum[WIDTH:1]};
         lo_d  = {sum[0], lo_q[WIDTH-1:1]};
      end
   end

   // Working registers: seeded on load, advanced on each step
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q  <= '0;
         lo_q   <= '0;
         opnd_q <= '0;
         div_q  <= 1'b0;
      end else if (load_i) begin
         acc_q  <= '0;
         lo_q   <= seed_i;
         opnd_q <= opnd_i;
         div_q  <= div_i;
      end else if (step_i) begin
         acc_q  <= acc_d;
         lo_q   <= lo_d;
      end
   end

   assign div_o    = div_q;
   assign res_hi_o = acc_d[WIDTH-1:0];
   assign res_lo_o = lo_d;

endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO multiply-divide unit: FSM, operand sign handling, result
// sign fix-up and the architectural HI/LO registers.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   logic [0:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, dvd_q, dvd_d;
   logic             done_q, done_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;

   logic             op_mul, op_div, sgn, a_neg, b_neg, load, step, core_div;
   logic [WIDTH-1:0] a_mag, b_mag, core_hi, core_lo;
   logic [2*WIDTH-1:0] prod, prod_fix;

   assign op_mul = is_mul(funct);
   assign op_div = is_div(funct);
   assign sgn    = ~funct[0];
   assign a_neg  = sgn & a[WIDTH-1];
   assign b_neg  = sgn & b[WIDTH-1];
   assign a_mag  = a_neg ? -a : a;
   assign b_mag  = b_neg ? -b : b;

   // Flush always wins, so a start in the flush cycle never loads the core
   assign load = !flush && (state_q == ST_IDLE) && start && (op_mul || op_div);
   assign step = !flush && (state_q == ST_RUN);

   muldiv_core #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .reset_n  (reset_n),
      .load_i   (load),
      .div_i    (op_div),
      .seed_i   (op_div ? a_mag : b_mag),
      .opnd_i   (op_div ? b_mag : a_mag),
      .step_i   (step),
      .div_o    (core_div),
      .res_hi_o (core_hi),
      .res_lo_o (core_lo)
   );

   assign prod     = {core_hi, core_lo};
   assign prod_fix = neg_q ? -prod : prod;

   // Next-state: FSM sequencing, operation capture, and final HI/LO write-back
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      dvd_d   = dvd_q;
      if (flush) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (state_q == ST_RUN) begin
         if (cnt_q == LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
            if (!core_div) begin
               {hi_d, lo_d} = prod_fix;
            end else if (dz_q) begin
               hi_d = dvd_q;
               lo_d = '1;
            end else begin
               lo_d = neg_q  ? -core_lo : core_lo;
               hi_d = rneg_q ? -core_hi : core_hi;
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (start) begin
         if (op_mul || op_div) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            dz_d    = (b == '0);
            dvd_d   = a;
         end else if (funct == F_MTHI) begin
            hi_d = a;
         end else if (funct == F_MTLO) begin
            lo_d = a;
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         dvd_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         dvd_q   <= dvd_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;

   localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010,
                          DIVU = 6'b011011, MTHI = 6'b010001, MTLO = 6'b010011;

   logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, flush = 1'b0;
   logic [5:0]  funct = '0;
   logic [31:0] a = '0, b = '0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int total = 0, bad = 0;
   logic [63:0] exp_q[$];
   logic [31:0] m_hi = '0, m_lo = '0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .funct(funct), .a(a), .b(b),
      .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference: {hi, lo} from plain integer arithmetic
   function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
      longint p;
      int sx, sy;
      sx = x; sy = y;
      case (f)
         MULT:  begin p = longint'(sx) * longint'(sy); return p; end
         MULTU: return {32'd0, x} * {32'd0, y};
         DIV: begin
            if (y == 0) return {x, 32'hFFFFFFFF};
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
            return {32'(sx % sy), 32'(sx / sy)};
         end
         default: begin
            if (y == 0) return {x, 32'hFFFFFFFF};
            return {x % y, x / y};
         end
      endcase
   endfunction

   // Monitor: every done pulse must match the oldest expected result
   always @(negedge clk) begin
      if (reset_n && done) begin
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL spurious_done got done=1 expected done=0 hi=%h lo=%h", hi, lo);
         end else begin
            chk("result", {hi, lo}, exp_q.pop_front());
         end
      end
   end

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Drive one request for one edge; returns at the negedge after it
   task automatic issue(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
      funct = f; a = x; b = y; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; funct = 6'($urandom); a = $urandom; b = $urandom;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic do_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
      int n;
      logic [63:0] r;
      if (f == MULT || f == MULTU || f == DIV || f == DIVU) begin
         r = ref_op(f, x, y);
         exp_q.push_back(r);
         {m_hi, m_lo} = r;
         issue(f, x, y);
         wait_idle(n);
         chk("busy_len", n, 32);
      end else begin
         if (f == MTHI) m_hi = x;
         if (f == MTLO) m_lo = x;
         issue(f, x, y);
         chk("move_busy", busy, 1'b0);
         chk("move_hilo", {hi, lo}, {m_hi, m_lo});
      end
   endtask

   initial begin
      int n;
      logic [5:0] f;
      #1;
      chk("reset_state", {busy, done, hi, lo}, '0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      // Directed corners
      do_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      chk("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
      do_op(MULT, 32'hFFFFFFFD, 32'd5);
      chk("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
      do_op(DIV, 32'hFFFFFFF9, 32'd2);
      chk("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
      do_op(DIVU, 32'd7, 32'd0);
      chk("divu_zero", {hi, lo}, 64'h00000007_FFFFFFFF);
      do_op(DIV, 32'h80000000, 32'hFFFFFFFF);
      do_op(DIV, 32'hFFFFFFF9, 32'd0);

      // mthi then div with an ignored second start while busy
      do_op(MTHI, 32'h12345678, 32'd0);
      exp_q.push_back(ref_op(DIV, 32'd100, 32'hFFFFFFF9));
      {m_hi, m_lo} = ref_op(DIV, 32'd100, 32'hFFFFFFF9);
      issue(DIV, 32'd100, 32'hFFFFFFF9);
      repeat (3) @(negedge clk);
      issue(MULTU, 32'd3, 32'd3);
      wait_idle(n);
      chk("busy_ignored_start", n, 28);

      // Flush at RUN cycle 10 of a mult
      do_op(MTHI, 32'hA5A5A5A5, 32'd0);
      do_op(MTLO, 32'hA5A5A5A5, 32'd0);
      issue(MULT, 32'd1234, 32'd5678);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      chk("flush_state", {busy, done}, 2'b00);
      chk("flush_hilo", {hi, lo}, 64'hA5A5A5A5_A5A5A5A5);
      repeat (40) @(negedge clk);

      // Flush in IDLE drops a coincident start
      flush = 1'b1;
      issue(MTHI, 32'hDEADBEEF, 32'd0);
      flush = 1'b0;
      chk("flush_drops_start", hi, 32'hA5A5A5A5);

      // Reset mid-div
      issue(DIV, 32'd1000, 32'd7);
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("async_reset", {busy, done, hi, lo}, '0);
      m_hi = '0; m_lo = '0;
      @(negedge clk);
      reset_n = 1'b1;
      do_op(MULT, 32'hFFFFFFFF, 32'h7FFFFFFF);

      // Random back-to-back traffic, including starts in the done cycle
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 7))
            0: f = MULT;
            1: f = MULTU;
            2: f = DIV;
            3: f = DIVU;
            4: f = MTHI;
            5: f = MTLO;
            6: f = 6'h10;
            default: f = 6'h20;
         endcase
         do_op(f, rnd_opnd(), rnd_opnd());
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
